// File: rtl/vga_timing_generator.sv
// 640x480@60 VGA raster timing: pixel-rate h/v counters, sync and blank decode,
// and a registered output stage aligned to the image generator's RGB latency.
module vga_timing_generator #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter int   CLK_DIV  = 4,
  parameter int   PIPE_DLY = 1,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [10:0] o_x,
  output logic [9:0]  o_y,
  output logic        o_pix_tick,
  output logic        o_frame_start,
  input  logic [3:0]  i_red,
  input  logic [3:0]  i_green,
  input  logic [3:0]  i_blue,
  output logic [3:0]  o_vga_red,
  output logic [3:0]  o_vga_green,
  output logic [3:0]  o_vga_blue,
  output logic        o_vga_hsync,
  output logic        o_vga_vsync
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_FP_START   = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_BP_START   = 11'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_FP_START   = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_BP_START   = 10'(V_ACTIVE + V_FP + V_SYNC);

  // Raster phase encoding, shared by the horizontal and vertical decoders.
  localparam logic [1:0] PH_ACTIVE = 2'd0;
  localparam logic [1:0] PH_FRONT  = 2'd1;
  localparam logic [1:0] PH_SYNC   = 2'd2;
  localparam logic [1:0] PH_BACK   = 2'd3;

  logic [DIV_W-1:0] div;
  logic [10:0]      h;
  logic [9:0]       v;
  logic             pix_tick;
  logic             frame_start;
  logic [1:0]       h_phase;
  logic [1:0]       v_phase;
  logic             hs_raw;
  logic             vs_raw;
  logic             act_raw;
  logic             hs_dly;
  logic             vs_dly;
  logic             act_dly;

  // With CLK_DIV == 1 div is stuck at 0, so the tick is high every cycle.
  assign pix_tick = (div == DIV_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div <= '0;
    end else if (pix_tick) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h           <= '0;
      v           <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pix_tick) begin
        if (h == H_LAST) begin
          h <= '0;
          if (v == V_LAST) begin
            v           <= '0;
            frame_start <= 1'b1;
          end else begin
            v <= v + 10'd1;
          end
        end else begin
          h <= h + 11'd1;
        end
      end
    end
  end

  always_comb begin
    h_phase = PH_BACK;
    if (h < H_FP_START) begin
      h_phase = PH_ACTIVE;
    end else if (h < H_SYNC_START) begin
      h_phase = PH_FRONT;
    end else if (h < H_BP_START) begin
      h_phase = PH_SYNC;
    end
  end

  always_comb begin
    v_phase = PH_BACK;
    if (v < V_FP_START) begin
      v_phase = PH_ACTIVE;
    end else if (v < V_SYNC_START) begin
      v_phase = PH_FRONT;
    end else if (v < V_BP_START) begin
      v_phase = PH_SYNC;
    end
  end

  assign hs_raw  = (h_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
  assign vs_raw  = (v_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
  assign act_raw = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);

  // Delay the decoded timing by the generator latency so it lines up with i_*.
  generate
    if (PIPE_DLY == 0) begin : g_no_dly
      assign hs_dly  = hs_raw;
      assign vs_dly  = vs_raw;
      assign act_dly = act_raw;
    end else begin : g_dly
      logic [PIPE_DLY-1:0] hs_sr;
      logic [PIPE_DLY-1:0] vs_sr;
      logic [PIPE_DLY-1:0] act_sr;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          hs_sr  <= {PIPE_DLY{~SYNC_POL}};
          vs_sr  <= {PIPE_DLY{~SYNC_POL}};
          act_sr <= '0;
        end else begin
          hs_sr[0]  <= hs_raw;
          vs_sr[0]  <= vs_raw;
          act_sr[0] <= act_raw;
          for (int i = 1; i < PIPE_DLY; i++) begin
            hs_sr[i]  <= hs_sr[i-1];
            vs_sr[i]  <= vs_sr[i-1];
            act_sr[i] <= act_sr[i-1];
          end
        end
      end

      assign hs_dly  = hs_sr[PIPE_DLY-1];
      assign vs_dly  = vs_sr[PIPE_DLY-1];
      assign act_dly = act_sr[PIPE_DLY-1];
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_vga_hsync <= ~SYNC_POL;
      o_vga_vsync <= ~SYNC_POL;
      o_vga_red   <= 4'h0;
      o_vga_green <= 4'h0;
      o_vga_blue  <= 4'h0;
    end else begin
      o_vga_hsync <= hs_dly;
      o_vga_vsync <= vs_dly;
      o_vga_red   <= act_dly ? i_red   : 4'h0;
      o_vga_green <= act_dly ? i_green : 4'h0;
      o_vga_blue  <= act_dly ? i_blue  : 4'h0;
    end
  end

  assign o_x           = h;
  assign o_y           = v;
  assign o_pix_tick    = pix_tick;
  assign o_frame_start = frame_start;

endmodule
